// File: rtl/sdram_frame_sched_if.sv
// Bus between the frame scheduler and its surroundings: capture/FIFO glue
// on one side, the SDRAM controller command port on the other.
interface sdram_frame_sched_if #(
   parameter int unsigned ADDR_W = 22
);
   logic              start;
   logic [9:0]        wr_usedw;
   logic [9:0]        rd_usedw;
   logic              cmd_ack;
   logic              cmd_done;
   logic              en_capture;
   logic              cmd_req;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic              wbuf;
   logic              rbuf;
   logic              frame_rdy;

   // Scheduler side.
   modport master (
      input  start, wr_usedw, rd_usedw, cmd_ack, cmd_done,
      output en_capture, cmd_req, cmd_wr, cmd_addr, wbuf, rbuf, frame_rdy
   );

   // Environment side (glue logic and SDRAM controller).
   modport slave (
      output start, wr_usedw, rd_usedw, cmd_ack, cmd_done,
      input  en_capture, cmd_req, cmd_wr, cmd_addr, wbuf, rbuf, frame_rdy
   );
endinterface

// File: rtl/sdram_frame_sched.sv
// Double-buffered frame scheduler: round-robin arbitration of write/read
// bursts into two SDRAM frame regions, with whole-frame capture dropping.
module sdram_frame_sched #(
   parameter int unsigned BURST       = 256,
   parameter int unsigned FRAME_WORDS = 307200,
   parameter int unsigned RD_LOW      = 256,
   parameter int unsigned ADDR_W      = 22,
   parameter int unsigned BUF0_BASE   = 0,
   parameter int unsigned BUF1_BASE   = 524288
) (
   input logic                 clk,
   input logic                 rst,
   sdram_frame_sched_if.master bus
);

   localparam int unsigned OFF_W = $clog2(FRAME_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_BUSY
   } state_t;

   state_t           state;
   logic             w_full;
   logic             last_wr;
   logic [OFF_W-1:0] woff;
   logic [OFF_W-1:0] roff;

   logic wreq_c;
   logic rreq_c;
   logic grant_wr_c;
   logic w_wrap_c;
   logic r_wrap_c;

   function automatic logic [ADDR_W-1:0] base_addr(input logic b);
      return b ? ADDR_W'(BUF1_BASE) : ADDR_W'(BUF0_BASE);
   endfunction

   // Pending requests, round-robin pick and end-of-frame detection.
   always_comb begin
      wreq_c     = (32'(bus.wr_usedw) >= BURST) && !w_full;
      rreq_c     = bus.frame_rdy && (32'(bus.rd_usedw) < RD_LOW);
      grant_wr_c = wreq_c && (!rreq_c || !last_wr);
      w_wrap_c   = (32'(woff) + BURST) == FRAME_WORDS;
      r_wrap_c   = (32'(roff) + BURST) == FRAME_WORDS;
   end

   // Command FSM with frame/buffer bookkeeping applied on burst completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         w_full         <= 1'b0;
         last_wr        <= 1'b0;
         woff           <= '0;
         roff           <= '0;
         bus.en_capture <= 1'b0;
         bus.cmd_req    <= 1'b0;
         bus.cmd_wr     <= 1'b0;
         bus.cmd_addr   <= '0;
         bus.wbuf       <= 1'b0;
         bus.rbuf       <= 1'b1;
         bus.frame_rdy  <= 1'b0;
      end else begin
         bus.en_capture <= bus.start && !w_full;
         case (state)
            S_IDLE: begin
               if (wreq_c || rreq_c) begin
                  bus.cmd_req  <= 1'b1;
                  bus.cmd_wr   <= grant_wr_c;
                  bus.cmd_addr <= grant_wr_c ? base_addr(bus.wbuf) + ADDR_W'(woff)
                                             : base_addr(bus.rbuf) + ADDR_W'(roff);
                  last_wr      <= grant_wr_c;
                  state        <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.cmd_ack) begin
                  bus.cmd_req <= 1'b0;
                  state       <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (bus.cmd_done) begin
                  state <= S_IDLE;
                  if (bus.cmd_wr) begin
                     if (w_wrap_c) begin
                        woff <= '0;
                        if (!bus.frame_rdy) begin
                           bus.rbuf      <= bus.wbuf;
                           bus.wbuf      <= ~bus.wbuf;
                           bus.frame_rdy <= 1'b1;
                        end else begin
                           w_full <= 1'b1;
                        end
                     end else begin
                        woff <= OFF_W'(32'(woff) + BURST);
                     end
                  end else begin
                     if (r_wrap_c) begin
                        roff <= '0;
                        // Without a fresh frame the display re-reads the current one.
                        if (w_full) begin
                           bus.wbuf <= bus.rbuf;
                           bus.rbuf <= bus.wbuf;
                           w_full   <= 1'b0;
                        end
                     end else begin
                        roff <= OFF_W'(32'(roff) + BURST);
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Bench for sdram_frame_sched: directed transaction table, mid-burst reset,
// then randomized traffic against a frame-level reference model.
module tb_sdram_frame_sched;

   localparam int unsigned BURST       = 256;
   localparam int unsigned FRAME_WORDS = 1024;
   localparam int unsigned RD_LOW      = 256;
   localparam int unsigned ADDR_W      = 22;
   localparam int unsigned B0          = 0;
   localparam int unsigned B1          = 524288;
   localparam int unsigned NB          = FRAME_WORDS / BURST;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   sdram_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

   sdram_frame_sched #(
      .BURST(BURST), .FRAME_WORDS(FRAME_WORDS), .RD_LOW(RD_LOW),
      .ADDR_W(ADDR_W), .BUF0_BASE(B0), .BUF1_BASE(B1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  wl;
      logic [9:0]  rl;
      bit          iss;
      bit          wr;
      int unsigned addr;
      bit          wb;
      bit          rb;
      bit          fr;
      bit          en;
   } vec_t;

   vec_t tbl [18];

   // reference model state, tracked in bursts per frame
   bit m_wfull, m_wbuf, m_rbuf, m_frdy, m_last;
   int m_wcnt, m_rcnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic quiet();
      bus.wr_usedw = 10'd0;
      bus.rd_usedw = 10'd1023;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      quiet();
      bus.cmd_ack  = 1'b0;
      bus.cmd_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_status(input string tag, input bit wb, input bit rb,
                               input bit fr, input bit en);
      check({tag, ".wbuf"},       32'(bus.wbuf),       32'(wb));
      check({tag, ".rbuf"},       32'(bus.rbuf),       32'(rb));
      check({tag, ".frame_rdy"},  32'(bus.frame_rdy),  32'(fr));
      check({tag, ".en_capture"}, 32'(bus.en_capture), 32'(en));
   endtask

   // Present FIFO levels, act as the SDRAM controller for one burst if requested.
   task automatic run_txn(input logic [9:0] wl, input logic [9:0] rl,
                          input int ack_dly, input int done_dly,
                          output bit issued, output bit wr, output int unsigned addr);
      issued = 1'b0;
      wr     = 1'b0;
      addr   = 0;
      bus.wr_usedw = wl;
      bus.rd_usedw = rl;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus.cmd_req) begin
            issued = 1'b1;
            break;
         end
      end
      quiet();
      if (issued) begin
         wr   = bus.cmd_wr;
         addr = 32'(bus.cmd_addr);
         for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk);
            #1;
            check("hold_req",  32'(bus.cmd_req),  32'd1);
            check("hold_addr", 32'(bus.cmd_addr), addr);
         end
         bus.cmd_ack = 1'b1;
         @(posedge clk);
         #1;
         bus.cmd_ack = 1'b0;
         check("req_drop", 32'(bus.cmd_req), 32'd0);
         for (int i = 0; i < done_dly; i++) begin
            @(posedge clk);
            #1;
         end
         bus.cmd_done = 1'b1;
         @(posedge clk);
         #1;
         bus.cmd_done = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      m_wfull = 0; m_wbuf = 0; m_rbuf = 1; m_frdy = 0; m_last = 0;
      m_wcnt  = 0; m_rcnt = 0;
   endtask

   task automatic model_grant(input logic [9:0] wl, input logic [9:0] rl,
                              output bit want, output bit is_wr, output int unsigned addr);
      bit w_want, r_want;
      w_want = (int'(wl) >= int'(BURST)) && !m_wfull;
      r_want = m_frdy && (int'(rl) < int'(RD_LOW));
      want   = w_want || r_want;
      if (w_want && r_want) is_wr = !m_last;
      else                  is_wr = w_want;
      if (is_wr) addr = (m_wbuf ? B1 : B0) + m_wcnt * BURST;
      else       addr = (m_rbuf ? B1 : B0) + m_rcnt * BURST;
      if (want) m_last = is_wr;
   endtask

   task automatic model_done(input bit is_wr);
      bit t;
      if (is_wr) begin
         m_wcnt++;
         if (m_wcnt == NB) begin
            m_wcnt = 0;
            if (!m_frdy) begin
               m_rbuf = m_wbuf; m_wbuf = !m_wbuf; m_frdy = 1;
            end else begin
               m_wfull = 1;
            end
         end
      end else begin
         m_rcnt++;
         if (m_rcnt == NB) begin
            m_rcnt = 0;
            if (m_wfull) begin
               t = m_wbuf; m_wbuf = m_rbuf; m_rbuf = t; m_wfull = 0;
            end
         end
      end
   endtask

   task automatic set_row(input int i, input int wl, input int rl, input bit iss,
                          input bit wr, input int unsigned addr, input bit wb,
                          input bit rb, input bit fr, input bit en);
      tbl[i] = '{wl: 10'(wl), rl: 10'(rl), iss: iss, wr: wr, addr: addr,
                 wb: wb, rb: rb, fr: fr, en: en};
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          iss, wr, m_want, m_wr, st;
      int unsigned addr, m_addr;
      logic [9:0]  wl, rl;

      // writes of frame 0, then alternate, then writer full, swap, repeat frame
      set_row( 0, 300,  0, 1, 1, B0+0,     0, 1, 0, 1);
      set_row( 1, 300,  0, 1, 1, B0+256,   0, 1, 0, 1);
      set_row( 2, 300,  0, 1, 1, B0+512,   0, 1, 0, 1);
      set_row( 3, 300,  0, 1, 1, B0+768,   1, 0, 1, 1);
      set_row( 4, 300, 300, 1, 1, B1+0,    1, 0, 1, 1);
      set_row( 5, 300,  0, 1, 0, B0+0,     1, 0, 1, 1);
      set_row( 6, 300,  0, 1, 1, B1+256,   1, 0, 1, 1);
      set_row( 7, 300, 300, 1, 1, B1+512,  1, 0, 1, 1);
      set_row( 8, 300, 300, 1, 1, B1+768,  1, 0, 1, 0);
      set_row( 9, 1000, 300, 0, 0, 0,      1, 0, 1, 0);
      set_row(10, 1000,  0, 1, 0, B0+256,  1, 0, 1, 0);
      set_row(11, 1000,  0, 1, 0, B0+512,  1, 0, 1, 0);
      set_row(12, 1000,  0, 1, 0, B0+768,  0, 1, 1, 1);
      set_row(13, 1000,  0, 1, 1, B0+0,    0, 1, 1, 1);
      set_row(14,   0,  0, 1, 0, B1+0,     0, 1, 1, 1);
      set_row(15,   0,  0, 1, 0, B1+256,   0, 1, 1, 1);
      set_row(16,   0,  0, 1, 0, B1+512,   0, 1, 1, 1);
      set_row(17,   0,  0, 1, 0, B1+768,   0, 1, 1, 1);

      bus.start = 1'b1;
      do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst.cmd_req",  32'(bus.cmd_req),  32'd0);
      check("rst.cmd_wr",   32'(bus.cmd_wr),   32'd0);
      check("rst.cmd_addr", 32'(bus.cmd_addr), 32'd0);
      check_status("rst", 0, 1, 0, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel.en_capture", 32'(bus.en_capture), 32'd1);

      for (int i = 0; i < 18; i++) begin
         run_txn(tbl[i].wl, tbl[i].rl, 2, 5, iss, wr, addr);
         check($sformatf("row%0d.issue", i), 32'(iss), 32'(tbl[i].iss));
         if (tbl[i].iss) begin
            check($sformatf("row%0d.wr", i),   32'(wr), 32'(tbl[i].wr));
            check($sformatf("row%0d.addr", i), addr,    tbl[i].addr);
         end
         check_status($sformatf("row%0d", i), tbl[i].wb, tbl[i].rb, tbl[i].fr, tbl[i].en);
      end

      // start falling keeps writes going, en_capture drops one cycle later
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("stop.en_capture", 32'(bus.en_capture), 32'd0);
      run_txn(10'd300, 10'd1023, 1, 1, iss, wr, addr);
      check("stop.issue", 32'(iss), 32'd1);
      check("stop.addr", addr, B0 + 256);
      bus.start = 1'b1;

      // reset while a burst is in flight, then a stray cmd_done
      do_reset();
      bus.wr_usedw = 10'd300;
      for (int i = 0; i < 8 && !bus.cmd_req; i++) begin
         @(posedge clk);
         #1;
      end
      quiet();
      bus.cmd_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_ack = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mrst.cmd_req", 32'(bus.cmd_req), 32'd0);
      check_status("mrst", 0, 1, 0, 0);
      bus.cmd_done = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_done = 1'b0;
      @(posedge clk);
      #1;
      check("stray_done.cmd_req", 32'(bus.cmd_req), 32'd0);
      run_txn(10'd300, 10'd0, 0, 0, iss, wr, addr);
      check("mrst.next_issue", 32'(iss), 32'd1);
      check("mrst.next_addr", addr, B0);
      check_status("mrst.next", 0, 1, 0, 1);

      // randomized traffic against the frame-level model
      do_reset();
      model_reset();
      st = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (n % 10 == 0) st = ($urandom_range(0, 5) != 0);
         bus.start = st;
         wl = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(256, 1023))
                                          : 10'($urandom_range(0, 255));
         rl = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 255))
                                          : 10'($urandom_range(256, 1023));
         model_grant(wl, rl, m_want, m_wr, m_addr);
         run_txn(wl, rl, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), iss, wr, addr);
         check($sformatf("rnd%0d.issue", n), 32'(iss), 32'(m_want));
         if (m_want && iss) begin
            check($sformatf("rnd%0d.wr", n),   32'(wr), 32'(m_wr));
            check($sformatf("rnd%0d.addr", n), addr,    m_addr);
         end
         if (m_want) model_done(m_wr);
         check_status($sformatf("rnd%0d", n), m_wbuf, m_rbuf, m_frdy, st && !m_wfull);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
